// File: rtl/decode_out_pipe_buf_pkg.sv
// Shared types for the decode-to-execute elastic buffer: the carried word layout,
// the NOP bubble value and the occupancy classification.
package decode_out_pipe_buf_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ECTRL_W = 6;
  localparam int DEF_WCTRL_W = 2;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]  ir;
    logic [DEF_DATA_W-1:0]  npc;
    logic [DEF_ECTRL_W-1:0] e_control;
    logic [DEF_WCTRL_W-1:0] w_control;
    logic                   mem_control;
  } decode_word_t;

  localparam decode_word_t NOP_WORD = '0;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_t;

endpackage

// File: rtl/decode_out_buf_mem.sv
// Word storage for decode_out_pipe_buf: registered write, asynchronous read.
// Holds no reset; the parent tracks which entries are valid.
module decode_out_buf_mem #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 41,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/decode_out_pipe_buf.sv
// Elastic decode-to-execute buffer with valid/ready handshake, flush and NOP bubbles.
// Optional macro DECODE_OUT_PIPE_BUF_STATS_EN adds stall_cnt / full_cnt counters.
//
// state       | meaning
// OCC_EMPTY   | count == 0, outputs show NOP, out_valid low
// OCC_PARTIAL | 0 < count < DEPTH, push and pop both allowed
// OCC_FULL    | count == DEPTH, in_ready low
module decode_out_pipe_buf
  import decode_out_pipe_buf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ECTRL_W = DEF_ECTRL_W,
  parameter int WCTRL_W = DEF_WCTRL_W,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_IR,
  input  logic [DATA_W-1:0]  in_npc,
  input  logic [ECTRL_W-1:0] in_E_control,
  input  logic [WCTRL_W-1:0] in_W_control,
  input  logic               in_Mem_control,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  IR,
  output logic [DATA_W-1:0]  npc_out,
  output logic [ECTRL_W-1:0] E_control,
  output logic [WCTRL_W-1:0] W_control,
  output logic               Mem_control,
  output logic [CNT_W-1:0]   count
`ifdef DECODE_OUT_PIPE_BUF_STATS_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        full_cnt
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WORD_W = 2 * DATA_W + ECTRL_W + WCTRL_W + 1;
  localparam logic [WORD_W-1:0] NOP = WORD_W'(NOP_WORD);

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [WORD_W-1:0] wr_word, head_word, out_word;
  logic              push, pop;
  occ_t              occ;

  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0)                occ = OCC_EMPTY;
    else if (count == CNT_W'(DEPTH)) occ = OCC_FULL;
  end

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (occ != OCC_FULL) && !reset;
  assign out_valid = (occ != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_word = {in_IR, in_npc, in_E_control, in_W_control, in_Mem_control};

  decode_out_buf_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W),
    .AW    (PTR_W)
  ) u_mem (
    .clock (clock),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_word = out_valid ? head_word : NOP;
  assign {IR, npc_out, E_control, W_control, Mem_control} = out_word;

`ifdef DECODE_OUT_PIPE_BUF_STATS_EN
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      stall_cnt <= '0;
      full_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (occ == OCC_FULL && in_valid && full_cnt != 16'hFFFF)
        full_cnt <= full_cnt + 16'd1;
    end
  end
`endif

endmodule
